// File: rtl/ddr_axi_frontend.sv
// AXI slave front-end of the DDR1 controller: splits single-ID, in-order AXI bursts
// into page-bounded sequencer commands and passes write/read beats straight through.
module ddr_axi_frontend #(
  parameter int   BA_BITS  = 2,
  parameter int   ROW_BITS = 13,
  parameter int   COL_BITS = 10,
  parameter int   DQ_LEVEL = 1,
  parameter logic FAIR_ARB = 1'b1,
  localparam int  AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
  localparam int  DW = 8 << DQ_LEVEL
) (
  input  logic                core_clk,
  input  logic                core_rstn_sync,
  input  logic                awvalid,
  output logic                awready,
  input  logic [AW-1:0]       awaddr,
  input  logic [7:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic                wlast,
  input  logic [DW-1:0]       wdata,
  output logic                bvalid,
  input  logic                bready,
  input  logic                arvalid,
  output logic                arready,
  input  logic [AW-1:0]       araddr,
  input  logic [7:0]          arlen,
  output logic                rvalid,
  input  logic                rready,
  output logic                rlast,
  output logic [DW-1:0]       rdata,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_write,
  output logic [BA_BITS-1:0]  cmd_ba,
  output logic [ROW_BITS-1:0] cmd_row,
  output logic [COL_BITS-1:0] cmd_col,
  output logic [7:0]          cmd_len,
  output logic                seq_wvalid,
  input  logic                seq_wready,
  output logic [DW-1:0]       seq_wdata,
  input  logic                seq_rvalid,
  output logic                seq_rready,
  input  logic [DW-1:0]       seq_rdata,
  output logic                proto_err
);

  localparam int BEAT_BYTES = 1 << DQ_LEVEL;
  localparam int PAGE_BEATS = 1 << (COL_BITS - 1);
  localparam int CW         = (COL_BITS > 9) ? COL_BITS : 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WCMD  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RCMD  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  logic [2:0]          state;
  logic [AW-1:0]       a;
  logic [8:0]          rem;
  logic [8:0]          seg_cnt;
  logic                last_grant_w;

  logic                grant_w;
  logic                in_cmd;
  logic                wbeat;
  logic                rbeat;
  logic [COL_BITS-2:0] bidx;
  logic [COL_BITS-1:0] page_left;
  logic [8:0]          seg_beats;

  // On a tie the fair arbiter hands the grant to whichever side did not win last.
  assign grant_w = awvalid && (!arvalid || !FAIR_ARB || !last_grant_w);
  assign awready = (state == S_IDLE) && awvalid && grant_w;
  assign arready = (state == S_IDLE) && arvalid && !grant_w;

  assign bidx      = a[DQ_LEVEL +: COL_BITS-1];
  assign page_left = COL_BITS'(PAGE_BEATS) - COL_BITS'(bidx);

  always_comb begin
    seg_beats = rem;
    if (CW'(page_left) < CW'(rem)) seg_beats = 9'(page_left);
  end

  assign in_cmd    = (state == S_WCMD) || (state == S_RCMD);
  assign cmd_valid = in_cmd;
  assign cmd_write = (state == S_WCMD);
  assign cmd_ba    = in_cmd ? a[AW-1 -: BA_BITS] : '0;
  assign cmd_row   = in_cmd ? a[DQ_LEVEL-1+COL_BITS +: ROW_BITS] : '0;
  assign cmd_col   = in_cmd ? a[DQ_LEVEL-1 +: COL_BITS] : '0;
  assign cmd_len   = in_cmd ? 8'(seg_beats - 9'd1) : '0;

  assign seq_wvalid = (state == S_WDATA) && wvalid;
  assign wready     = (state == S_WDATA) && seq_wready;
  assign seq_wdata  = wdata;
  assign rvalid     = (state == S_RDATA) && seq_rvalid;
  assign seq_rready = (state == S_RDATA) && rready;
  assign rdata      = seq_rdata;
  assign rlast      = (state == S_RDATA) && (rem == 9'd1);
  assign bvalid     = (state == S_WRESP);

  assign wbeat = (state == S_WDATA) && wvalid && seq_wready;
  assign rbeat = (state == S_RDATA) && seq_rvalid && rready;

  // NOTE: state registers use non-blocking assignments only; all outputs above are
  // continuous assigns, so no path can infer a latch.
  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state        <= S_IDLE;
      a            <= '0;
      rem          <= '0;
      seg_cnt      <= '0;
      last_grant_w <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (awready) begin
            a            <= awaddr;
            rem          <= {1'b0, awlen} + 9'd1;
            last_grant_w <= 1'b1;
            state        <= S_WCMD;
          end else if (arready) begin
            a            <= araddr;
            rem          <= {1'b0, arlen} + 9'd1;
            last_grant_w <= 1'b0;
            state        <= S_RCMD;
          end
        end
        S_WCMD, S_RCMD: begin
          if (cmd_ready) begin
            seg_cnt <= seg_beats;
            state   <= (state == S_WCMD) ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA, S_RDATA: begin
          if (wbeat || rbeat) begin
            seg_cnt <= seg_cnt - 9'd1;
            rem     <= rem - 9'd1;
            a       <= a + AW'(BEAT_BYTES);
            // Burst end wins over segment end; a segment end re-issues a command.
            if (rem == 9'd1)
              state <= (state == S_WDATA) ? S_WRESP : S_IDLE;
            else if (seg_cnt == 9'd1)
              state <= (state == S_WDATA) ? S_WCMD : S_RCMD;
          end
        end
        S_WRESP: begin
          if (bready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wbeat && (wlast != (rem == 9'd1))) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_axi_frontend.sv
// Randomized self-checking bench for ddr_axi_frontend: a reference model derives
// the expected page-split commands, beat counts, arbitration and error flag.
module tb_ddr_axi_frontend;

  localparam int BA_BITS  = 2;
  localparam int ROW_BITS = 13;
  localparam int COL_BITS = 10;
  localparam int DQ_LEVEL = 1;
  localparam int AW       = 25;
  localparam int DW       = 16;
  localparam int TMO      = 500;

  typedef logic [33:0] cmd_t;

  logic                core_clk;
  logic                core_rstn_sync;
  logic                awvalid, awready;
  logic [AW-1:0]       awaddr;
  logic [7:0]          awlen;
  logic                wvalid, wready, wlast;
  logic [DW-1:0]       wdata;
  logic                bvalid, bready;
  logic                arvalid, arready;
  logic [AW-1:0]       araddr;
  logic [7:0]          arlen;
  logic                rvalid, rready, rlast;
  logic [DW-1:0]       rdata;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [BA_BITS-1:0]  cmd_ba;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic [7:0]          cmd_len;
  logic                seq_wvalid, seq_wready;
  logic [DW-1:0]       seq_wdata;
  logic                seq_rvalid, seq_rready;
  logic [DW-1:0]       seq_rdata;
  logic                proto_err;

  ddr_axi_frontend #(
    .BA_BITS (BA_BITS),
    .ROW_BITS(ROW_BITS),
    .COL_BITS(COL_BITS),
    .DQ_LEVEL(DQ_LEVEL),
    .FAIR_ARB(1'b1)
  ) dut (
    .core_clk      (core_clk),
    .core_rstn_sync(core_rstn_sync),
    .awvalid       (awvalid),
    .awready       (awready),
    .awaddr        (awaddr),
    .awlen         (awlen),
    .wvalid        (wvalid),
    .wready        (wready),
    .wlast         (wlast),
    .wdata         (wdata),
    .bvalid        (bvalid),
    .bready        (bready),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .arlen         (arlen),
    .rvalid        (rvalid),
    .rready        (rready),
    .rlast         (rlast),
    .rdata         (rdata),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_ba        (cmd_ba),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .cmd_len       (cmd_len),
    .seq_wvalid    (seq_wvalid),
    .seq_wready    (seq_wready),
    .seq_wdata     (seq_wdata),
    .seq_rvalid    (seq_rvalid),
    .seq_rready    (seq_rready),
    .seq_rdata     (seq_rdata),
    .proto_err     (proto_err)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int   n_checks = 0;
  int   n_errors = 0;
  cmd_t exp_cmd_q[$];
  bit   exp_perr   = 1'b0;
  bit   exp_last_w = 1'b0;
  bit   mon_en     = 1'b0;
  int   w_seen, r_seen, r_len, r_total, b_cnt, b_exp, rd_idx;
  bit   r_hs_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rdata_fn(input int n);
    return DW'(n * 40503 + 23130);
  endfunction

  // Expected segments: each runs to the end of the current page or of the burst.
  function automatic void push_cmds(input bit w, input logic [AW-1:0] addr, input logic [7:0] len);
    int unsigned cur  = 32'(addr);
    int          left = int'(len) + 1;
    while (left > 0) begin
      int bidx = int'((cur / 2) % 512);
      int seg  = (left < 512 - bidx) ? left : 512 - bidx;
      exp_cmd_q.push_back({w, 2'(cur >> 23), 13'(cur >> 10), 10'(cur % 1024), 8'(seg - 1)});
      cur  = (cur + 2 * seg) % 32'h200_0000;
      left = left - seg;
    end
  endfunction

  // Sequencer stand-in: random backpressure, read data numbered by delivered beat.
  initial begin
    rd_idx = 0; r_hs_pend = 1'b0;
    cmd_ready = 1'b0; seq_wready = 1'b0; seq_rvalid = 1'b0; seq_rdata = rdata_fn(0);
  end
  always @(negedge core_clk) r_hs_pend = seq_rvalid && seq_rready;
  always @(posedge core_clk) begin
    #1;
    if (r_hs_pend) rd_idx++;
    seq_rdata  = rdata_fn(rd_idx);
    seq_rvalid = ($urandom_range(3) != 0);
    cmd_ready  = ($urandom_range(2) != 0);
    seq_wready = ($urandom_range(3) != 0);
  end

  always @(negedge core_clk) begin
    if (mon_en) begin
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", cmd_valid, 1'b0);
        else begin
          check("cmd_fields", {cmd_write, cmd_ba, cmd_row, cmd_col, cmd_len}, exp_cmd_q[0]);
          if (cmd_ready) void'(exp_cmd_q.pop_front());
        end
      end
      if (seq_wvalid && seq_wready) begin
        check("seq_wdata", seq_wdata, wdata);
        w_seen++;
      end
      if (rvalid && rready) begin
        check("rdata", rdata, rdata_fn(r_total));
        check("rlast", rlast, r_seen == r_len);
        r_seen++;
        r_total++;
      end
      if (bvalid && bready) b_cnt++;
      check("proto_err", proto_err, exp_perr);
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    core_rstn_sync = 1'b0;
    awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wlast = 0; wdata = '0; bready = 0;
    arvalid = 0; araddr = '0; arlen = '0; rready = 0;
    exp_cmd_q.delete();
    exp_perr = 1'b0; exp_last_w = 1'b0;
    #1;
    check("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, cmd_valid,
                            seq_wvalid, seq_rready, proto_err, cmd_write, cmd_ba, cmd_row,
                            cmd_col, cmd_len}, '0);
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    core_rstn_sync = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic aw_wait();
    int n = 0;
    do begin @(negedge core_clk); n++; end while (!awready && n < TMO);
    check("awready_wait", awready, 1'b1);
  endtask

  task automatic ar_wait();
    int n = 0;
    do begin @(negedge core_clk); n++; end while (!arready && n < TMO);
    check("arready_wait", arready, 1'b1);
  endtask

  // Called on the negedge before the AW handshake edge.
  task automatic aw_done();
    push_cmds(1'b1, awaddr, awlen);
    exp_last_w = 1'b1;
    w_seen = 0;
    @(posedge core_clk); #1;
    awvalid = 1'b0;
    @(negedge core_clk);
    check("cmd_valid_after_aw", cmd_valid, 1'b1);
  endtask

  task automatic ar_done();
    push_cmds(1'b0, araddr, arlen);
    exp_last_w = 1'b0;
    r_seen = 0; r_len = int'(arlen);
    @(posedge core_clk); #1;
    arvalid = 1'b0;
    @(negedge core_clk);
    check("cmd_valid_after_ar", cmd_valid, 1'b1);
  endtask

  // Returns just after the B handshake edge.
  task automatic w_data_b(input int len, input int bad, input bit drop_last,
                          input logic [AW-1:0] base, input int hold);
    @(posedge core_clk); #1;
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      bit wl;
      wl = ((i == len) && !drop_last) || (i == bad);
      wvalid = 1'b1; wlast = wl; wdata = DW'(32'(base) + 2 * i);
      do begin @(negedge core_clk); n++; end while (!wready && n < TMO);
      check("wready_wait", wready, 1'b1);
      @(posedge core_clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (wl != (i == len)) exp_perr = 1'b1;
      if (i != len && $urandom_range(3) == 0) begin @(posedge core_clk); #1; end
    end
    bready = (hold == 0);
    @(negedge core_clk);
    check("bvalid_latency", bvalid, 1'b1);
    check("w_beats", 64'(w_seen), 64'(len + 1));
    for (int k = 0; k < hold; k++) begin
      @(posedge core_clk); #1;
      if (k == hold - 1) bready = 1'b1;
      @(negedge core_clk);
      check("bvalid_hold", bvalid, 1'b1);
    end
    b_exp++;
    @(posedge core_clk); #1;
    bready = 1'b0;
  endtask

  task automatic post_b();
    @(negedge core_clk);
    check("bvalid_clear", bvalid, 1'b0);
    check("b_count", 64'(b_cnt), 64'(b_exp));
    check("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
  endtask

  // Returns just after the last accepted beat edge (or after abort_after beats).
  task automatic r_data(input int len, input int abort_after);
    int got = 0;
    int n = 0;
    @(posedge core_clk); #1;
    while (got <= len && n < TMO) begin
      rready = $urandom_range(1);
      @(negedge core_clk); n++;
      if (rvalid && rready) got++;
      @(posedge core_clk); #1;
      if (abort_after > 0 && got == abort_after) break;
    end
    rready = 1'b0;
    if (abort_after == 0) check("r_beats_done", 64'(got), 64'(len + 1));
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input int bad,
                          input bit drop_last, input int hold);
    @(posedge core_clk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    aw_wait();
    aw_done();
    w_data_b(len, bad, drop_last, addr, hold);
    post_b();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input int abort_after);
    @(posedge core_clk); #1;
    arvalid = 1'b1; araddr = addr; arlen = 8'(len);
    ar_wait();
    ar_done();
    r_data(len, abort_after);
    if (abort_after == 0) begin
      @(negedge core_clk);
      check("r_beats_mon", 64'(r_seen), 64'(len + 1));
      check("idle_after_r", {cmd_valid, rvalid}, 2'b00);
      check("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    w_seen = 0; r_seen = 0; r_len = 0; r_total = 0; b_cnt = 0; b_exp = 0;
    do_reset();

    // Directed scenarios
    do_write(25'd0, 7, -1, 1'b0, 0);
    do_write(25'd1020, 7, -1, 1'b0, 1);
    do_read(25'd1020, 7, 0);
    do_read(25'h1FF_FFFC, 3, 0);

    // Arbitration ties starting from reset
    do_reset();
    @(posedge core_clk); #1;
    awvalid = 1'b1; awaddr = 25'h0_0400; awlen = 8'd3;
    arvalid = 1'b1; araddr = 25'h0_0800; arlen = 8'd2;
    @(negedge core_clk);
    check("tie1_awready", awready, !exp_last_w);
    check("tie1_arready", arready, exp_last_w);
    aw_done();
    w_data_b(3, -1, 1'b0, 25'h0_0400, 0);
    awvalid = 1'b1; awaddr = 25'h0_0C00; awlen = 8'd1;
    @(negedge core_clk);
    check("bvalid_clear", bvalid, 1'b0);
    check("b_count", 64'(b_cnt), 64'(b_exp));
    check("tie2_awready", awready, !exp_last_w);
    check("tie2_arready", arready, exp_last_w);
    ar_done();
    r_data(2, 0);
    aw_wait();
    aw_done();
    w_data_b(1, -1, 1'b0, 25'h0_0C00, 0);
    post_b();

    // Randomized mix, biased toward page-crossing start addresses
    for (int t = 0; t < 24; t++) begin
      int unsigned ad;
      int ln;
      ad = $urandom & 32'h01FF_FFFE;
      ln = $urandom_range(40);
      if ($urandom_range(1) == 1) ad = (ad & ~32'h3FE) | (32'($urandom_range(511, 500)) << 1);
      if ($urandom_range(1) == 1) do_write(25'(ad), ln, -1, 1'b0, $urandom_range(2));
      else do_read(25'(ad), ln, 0);
    end

    // Early WLAST on beat 3; the burst still runs to completion
    do_write(25'h0_2000, 7, 2, 1'b0, 0);

    // Reset after 4 of 8 read beats, then a clean write
    do_read(25'd0, 7, 4);
    do_reset();
    do_write(25'd0, 7, -1, 1'b0, 0);

    // Final beat without WLAST
    do_write(25'h0_4000, 3, -1, 1'b1, 0);

    repeat (2) @(negedge core_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
